// File: rtl/usb2_pkg.sv
// Shared definitions for the USB 2.0 external IN-buffer arbiter.
package usb2_pkg;

    localparam int USB2_ADDR_W = 9;
    localparam int USB2_LEN_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_LOW = 2'd3
    } arb_state_t;

endpackage

// File: rtl/usb2_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module usb2_rr_arb #(
    parameter int N_CH  = 4,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [IDX_W-1:0]  off;
    logic [SUM_W-1:0]  sum;

    // Rotate requests so ptr sits at bit 0, find the lowest set bit, rotate back
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_CH-1:0];
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SUM_W'(N_CH)) sum = sum - SUM_W'(N_CH);
        idx = sum[IDX_W-1:0];
        gnt = (|rot) ? (N_CH'(1) << idx) : '0;
    end

endmodule

// File: rtl/usb2_ep_in_arbiter.sv
// N-channel arbiter sharing the core's single IN-buffer write/commit port.
module usb2_ep_in_arbiter
    import usb2_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = USB2_ADDR_W,
    parameter int LEN_W   = USB2_LEN_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                    ext_clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         ch_req,
    output logic [N_CH-1:0]         ch_gnt,
    input  logic [N_CH*ADDR_W-1:0]  ch_addr,
    input  logic [N_CH*8-1:0]       ch_data,
    input  logic [N_CH-1:0]         ch_wren,
    input  logic [N_CH-1:0]         ch_commit,
    input  logic [N_CH*LEN_W-1:0]   ch_commit_len,
    output logic [N_CH-1:0]         ch_commit_ack,
    output logic [N_CH-1:0]         ch_abort,
    output logic [ADDR_W-1:0]       buf_in_addr,
    output logic [7:0]              buf_in_data,
    output logic                    buf_in_wren,
    input  logic                    buf_in_ready,
    output logic                    buf_in_commit,
    output logic [LEN_W-1:0]        buf_in_commit_len,
    input  logic                    buf_in_commit_ack,
    output logic                    err_len,
    output logic [3:0]              stat_owner
);

    localparam int     IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int     CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam longint MAX_LEN = longint'(1) << ADDR_W;

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  owner, rr_ptr, pick_idx;
    logic [N_CH-1:0]   gnt_q, pick_gnt, ack_q, abort_q;
    logic [CNT_W-1:0]  wdog_cnt;
    logic [LEN_W-1:0]  len_q, len_sel, len_clamp;
    logic              err_q, len_sat;
    logic              own_wren, own_commit, own_req, idle_cyc, wdog_hit;
    logic              do_grant, do_commit, do_ack, do_revoke;

    logic [N_CH-1:0][ADDR_W-1:0] addr_arr;
    logic [N_CH-1:0][7:0]        data_arr;
    logic [N_CH-1:0][LEN_W-1:0]  len_arr;

    assign addr_arr = ch_addr;
    assign data_arr = ch_data;
    assign len_arr  = ch_commit_len;

    usb2_rr_arb #(.N_CH(N_CH), .IDX_W(IDX_W)) u_rr (
        .req (ch_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign own_wren   = ch_wren[owner] & (state == ST_GRANT);
    assign own_commit = ch_commit[owner];
    assign own_req    = ch_req[owner];
    assign idle_cyc   = !own_wren && !own_commit;
    assign wdog_hit   = (TIMEOUT != 0) && idle_cyc && (wdog_cnt == CNT_W'(TIMEOUT - 1));

    // Oversized commits are clamped to the buffer size and flagged
    assign len_sel   = len_arr[owner];
    assign len_sat   = (longint'(len_sel) > MAX_LEN);
    assign len_clamp = len_sat ? LEN_W'(MAX_LEN) : len_sel;

    // Next-state and one-cycle control strobes; commit wins over release and revoke
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_commit = 1'b0;
        do_ack    = 1'b0;
        do_revoke = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_in_ready && (|ch_req)) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (own_commit) begin
                    do_commit = 1'b1;
                    state_nxt = ST_COMMIT;
                end else if (!own_req) begin
                    state_nxt = ST_IDLE;
                end else if (wdog_hit) begin
                    do_revoke = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (buf_in_commit_ack) begin
                    do_ack    = 1'b1;
                    state_nxt = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!buf_in_commit_ack && !own_commit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Owner, RR pointer, commit length, watchdog and pulse outputs
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            owner    <= '0;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            ack_q    <= '0;
            abort_q  <= '0;
            wdog_cnt <= '0;
        end else begin
            ack_q   <= do_ack ? gnt_q : '0;
            abort_q <= do_revoke ? gnt_q : '0;
            err_q   <= do_commit && len_sat;
            if (do_grant) begin
                owner  <= pick_idx;
                gnt_q  <= pick_gnt;
                rr_ptr <= (pick_idx == IDX_W'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (do_commit) len_q <= len_clamp;
            if (state != ST_GRANT || state_nxt != ST_GRANT || own_wren)
                wdog_cnt <= '0;
            else if (TIMEOUT != 0 && idle_cyc)
                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign ch_gnt            = (state == ST_GRANT || state == ST_COMMIT) ? gnt_q : '0;
    assign ch_commit_ack     = ack_q;
    assign ch_abort          = abort_q;
    assign buf_in_wren       = own_wren;
    assign buf_in_addr       = (state == ST_GRANT) ? addr_arr[owner] : '0;
    assign buf_in_data       = (state == ST_GRANT) ? data_arr[owner] : '0;
    assign buf_in_commit     = (state == ST_COMMIT);
    assign buf_in_commit_len = len_q;
    assign err_len           = err_q;
    assign stat_owner        = 4'(owner);

endmodule

// File: tb/tb_usb2_ep_in_arbiter.sv
// Randomized bench for usb2_ep_in_arbiter against a transaction-level model.
module tb_usb2_ep_in_arbiter;

    localparam int N    = 4;
    localparam int AW   = 9;
    localparam int LW   = 10;
    localparam int TO   = 16;
    localparam int MAXL = 512;
    localparam logic [N*AW-1:0] AMASK = (N*AW)'({AW{1'b1}});
    localparam logic [N*8-1:0]  DMASK = (N*8)'(8'hFF);
    localparam logic [N*LW-1:0] LMASK = (N*LW)'({LW{1'b1}});

    logic            ext_clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    ch_req, ch_gnt, ch_wren, ch_commit, ch_commit_ack, ch_abort;
    logic [N*AW-1:0] ch_addr;
    logic [N*8-1:0]  ch_data;
    logic [N*LW-1:0] ch_commit_len;
    logic [AW-1:0]   buf_in_addr;
    logic [7:0]      buf_in_data;
    logic            buf_in_wren, buf_in_ready, buf_in_commit, buf_in_commit_ack, err_len;
    logic [LW-1:0]   buf_in_commit_len;
    logic [3:0]      stat_owner;

    int n_chk = 0, n_fail = 0, ptr = 0, wr_seen = 0;

    always #5 ext_clk = ~ext_clk;

    usb2_ep_in_arbiter #(.N_CH(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .ext_clk(ext_clk), .reset_n(reset_n),
        .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_addr(ch_addr), .ch_data(ch_data),
        .ch_wren(ch_wren), .ch_commit(ch_commit), .ch_commit_len(ch_commit_len),
        .ch_commit_ack(ch_commit_ack), .ch_abort(ch_abort),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .err_len(err_len), .stat_owner(stat_owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Grant must never name more than one channel; also tally writes seen by the core
    always @(negedge ext_clk) begin
        chk("gnt_onehot", 32'($onehot0(ch_gnt)), 32'd1);
        if (buf_in_wren === 1'b1) wr_seen++;
    end

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // Reference pick: first requester at or after the pointer, wrapping
    function automatic int rr_pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++)
            if (((req >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
        return -1;
    endfunction

    task automatic tick;
        @(posedge ext_clk);
        #1;
    endtask

    task automatic put_ch(input int c, input logic [AW-1:0] a, input logic [7:0] d);
        ch_addr = (ch_addr & ~(AMASK << (c * AW))) | ((N*AW)'(a) << (c * AW));
        ch_data = (ch_data & ~(DMASK << (c * 8))) | ((N*8)'(d) << (c * 8));
    endtask

    task automatic put_len(input int c, input int len);
        ch_commit_len = (ch_commit_len & ~(LMASK << (c * LW))) | ((N*LW)'(LW'(len)) << (c * LW));
    endtask

    task automatic await_gnt(input int exp);
        int k = 0;
        do begin
            tick();
            k++;
        end while (ch_gnt == '0 && k < 20);
        chk("gnt_lat", k, 1);
        chk("gnt", ch_gnt, onehot(exp));
        chk("owner", stat_owner, exp);
        chk("abort_quiet", ch_abort, 0);
        ptr = (exp + 1) % N;
    endtask

    // Owner writes nwr beats while a non-owner drives decoy writes/commits
    task automatic burst(input int own, input int nwr, input int base);
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            oth;
        for (int i = 0; i < nwr; i++) begin
            a   = AW'(base + i);
            d   = 8'($urandom);
            oth = (own + 1 + $urandom_range(0, N - 2)) % N;
            put_ch(own, a, d);
            put_ch(oth, ~a, ~d);
            ch_wren   = onehot(own) | onehot(oth);
            ch_commit = ($urandom_range(0, 1) != 0) ? onehot(oth) : '0;
            #1;
            chk("wr_en", buf_in_wren, 1);
            chk("wr_addr", buf_in_addr, a);
            chk("wr_data", buf_in_data, d);
            tick();
        end
        ch_wren   = '0;
        ch_commit = '0;
    endtask

    // Writes, a final write alongside the commit, then the commit/ack handshake
    task automatic serve(input int own, input int nwr, input int len, input int base);
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            exp_len, dly;
        burst(own, nwr, base);
        a = AW'(base + nwr);
        d = 8'($urandom);
        put_ch(own, a, d);
        put_len(own, len);
        ch_wren   = onehot(own);
        ch_commit = onehot(own);
        #1;
        chk("wr_with_commit", {buf_in_wren, buf_in_addr, buf_in_data}, {1'b1, a, d});
        tick();
        ch_wren = '0;
        exp_len = (len > MAXL) ? MAXL : len;
        chk("cm_commit", buf_in_commit, 1);
        chk("cm_len", buf_in_commit_len, exp_len);
        chk("cm_err", err_len, (len > MAXL) ? 1 : 0);
        chk("cm_gnt", ch_gnt, onehot(own));
        dly = $urandom_range(0, 3);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("cm_hold", {buf_in_commit, buf_in_commit_len}, {1'b1, LW'(exp_len)});
            chk("cm_err_once", err_len, 0);
            chk("cm_noack", ch_commit_ack, 0);
        end
        buf_in_commit_ack = 1'b1;
        tick();
        chk("ack", ch_commit_ack, onehot(own));
        chk("ack_gnt", ch_gnt, 0);
        chk("ack_commit", buf_in_commit, 0);
        tick();
        chk("ack_once", ch_commit_ack, 0);
        chk("wl_gnt", ch_gnt, 0);
        buf_in_commit_ack = 1'b0;
        ch_commit         = '0;
        tick();
        chk("idle_gnt", ch_gnt, 0);
    endtask

    // Writes, then silence from the owner until the watchdog revokes
    task automatic timeout(input int own, input int nwr);
        int c = 1;
        burst(own, nwr, $urandom);
        ch_wren = onehot((own + 1 + $urandom_range(0, N - 2)) % N);
        while (c < 40) begin
            tick();
            if (ch_gnt == '0) break;
            c++;
            ch_wren = onehot((own + 1 + $urandom_range(0, N - 2)) % N);
        end
        ch_wren = '0;
        chk("wdog_cycles", c, TO);
        chk("abort", ch_abort, onehot(own));
        chk("abort_noack", ch_commit_ack, 0);
    endtask

    // Owner gives up without committing
    task automatic drop(input int own, input int nwr);
        burst(own, nwr, $urandom);
        ch_req = ch_req & ~onehot(own);
        tick();
        chk("drop_gnt", ch_gnt, 0);
        chk("drop_ack", ch_commit_ack, 0);
        chk("drop_abort", ch_abort, 0);
    endtask

    initial begin
        int own, m, base_wr;
        int lens[3] = '{512, 513, 1023};
        ch_req = '0; ch_wren = '0; ch_commit = '0;
        ch_addr = '0; ch_data = '0; ch_commit_len = '0;
        buf_in_ready = 1'b1; buf_in_commit_ack = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge ext_clk);
        #1;
        chk("rst_gnt", ch_gnt, 0);
        chk("rst_pulses", {ch_commit_ack, ch_abort, err_len}, 0);
        chk("rst_bus", {buf_in_wren, buf_in_addr, buf_in_data}, 0);
        chk("rst_commit", {buf_in_commit, buf_in_commit_len}, 0);
        chk("rst_owner", stat_owner, 0);
        reset_n = 1'b1;
        tick();

        // all four requesting: order 0,1,2,3,0
        ch_req = '1;
        for (int i = 0; i < 5; i++) begin
            own = rr_pick(ch_req, ptr);
            await_gnt(own);
            chk("rr_order", stat_owner, i % N);
            serve(own, 7, 8, $urandom);
        end

        // single channel, 64 sequential writes then commit of 64
        ch_req  = 4'b0100;
        base_wr = wr_seen;
        await_gnt(rr_pick(ch_req, ptr));
        serve(2, 63, 64, 0);
        chk("wr_total", wr_seen - base_wr, 64);

        // core not ready: requests wait
        ch_req = 4'b1010;
        buf_in_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nrdy_gnt", ch_gnt, 0);
        end
        buf_in_ready = 1'b1;
        own = rr_pick(ch_req, ptr);
        await_gnt(own);
        serve(own, 2, 600, $urandom);

        // watchdog on ch1, then ch2 takes over
        ch_req = 4'b0010;
        await_gnt(rr_pick(ch_req, ptr));
        ch_req = 4'b0110;
        timeout(1, 0);
        own = rr_pick(ch_req, ptr);
        await_gnt(own);
        chk("after_abort", own, 2);
        drop(own, 3);

        // length boundaries
        foreach (lens[i]) begin
            ch_req = N'($urandom_range(1, (1 << N) - 1));
            own = rr_pick(ch_req, ptr);
            await_gnt(own);
            serve(own, 1, lens[i], $urandom);
        end

        // random mix of transaction kinds
        for (int r = 0; r < 30; r++) begin
            ch_req = N'($urandom_range(1, (1 << N) - 1));
            own = rr_pick(ch_req, ptr);
            await_gnt(own);
            m = $urandom_range(0, 9);
            if (m < 6)      serve(own, $urandom_range(0, 6), $urandom_range(0, 1023), $urandom);
            else if (m < 8) timeout(own, $urandom_range(0, 3));
            else            drop(own, $urandom_range(0, 3));
        end

        // reset during COMMIT
        ch_req = 4'b1000;
        own = rr_pick(ch_req, ptr);
        await_gnt(own);
        put_len(own, 20);
        ch_commit = onehot(own);
        tick();
        chk("rstc_pre", buf_in_commit, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstc_commit", buf_in_commit, 0);
        chk("rstc_gnt", ch_gnt, 0);
        chk("rstc_pulses", {ch_commit_ack, ch_abort}, 0);
        ch_commit = '0;
        ch_req    = '1;
        tick();
        reset_n = 1'b1;
        ptr = 0;
        own = rr_pick(ch_req, ptr);
        await_gnt(own);
        chk("rstc_ptr", stat_owner, 0);
        serve(own, 2, 5, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        chk("global_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/usb2_ep_in_arbiter.md
Name: usb2_ep_in_arbiter

Overview:
Parametrised N-channel arbiter in front of the USB 2.0 core's single external IN-buffer write/commit interface. It lets several user-side producers share one endpoint buffer: round-robin grant, zero-latency write-path mux for the owner, a commit/ack relay and an idle-timeout watchdog. It sits between user logic and the core's ext-side buf_in_* ports, entirely in the ext_clk domain.

Parameters:
N_CH, 4, number of producer channels (2..16)
ADDR_W, 9, buffer address width
LEN_W, 10, commit length width
TIMEOUT, 1024, max idle cycles while granted before revoke; 0 disables watchdog

Ports:
ext_clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
ch_req  in  N_CH  per-channel request, level
ch_gnt  out  N_CH  one-hot grant
ch_addr  in  N_CH*ADDR_W  per-channel write address, packed, ch0 at LSBs
ch_data  in  N_CH*8  per-channel write data, packed
ch_wren  in  N_CH  per-channel write enable
ch_commit  in  N_CH  per-channel commit request, level
ch_commit_len  in  N_CH*LEN_W  per-channel commit length, packed
ch_commit_ack  out  N_CH  one-cycle commit done pulse
ch_abort  out  N_CH  one-cycle pulse when a grant is revoked by the watchdog
buf_in_addr  out  ADDR_W  to core
buf_in_data  out  8  to core
buf_in_wren  out  1  to core
buf_in_ready  in  1  core buffer free
buf_in_commit  out  1  to core, level until ack
buf_in_commit_len  out  LEN_W  to core
buf_in_commit_ack  in  1  core commit acknowledge
err_len  out  1  one-cycle pulse on saturated commit length
stat_owner  out  4  index of granted channel, valid when any ch_gnt is high

Behaviour:
- Reset: every output is 0. FSM is IDLE. The RR pointer is 0, so ch0 has highest priority first. The watchdog counter is 0.
- Reset mid-operation drops the grant and buf_in_commit immediately. No ack or abort is emitted.
- States: IDLE, GRANT, COMMIT, WAIT_LOW.
- IDLE: when buf_in_ready=1 and any ch_req is high, pick the first requester at or after the RR pointer (wrapping). On the next edge assert its ch_gnt, set stat_owner, set the RR pointer to owner+1 mod N_CH, and go to GRANT. Latency is req to gnt = 1 cycle.
- GRANT: buf_in_addr/data/wren are combinationally muxed from the owner, with wren ANDed with ch_gnt. Non-owner wren is ignored. When not in GRANT, buf_in_wren=0.
  - Owner ch_commit=1: register commit_len, go to COMMIT, and assert buf_in_commit on the next cycle. A wren in the same cycle as commit is still forwarded.
  - Owner ch_req drops without commit: release to IDLE with no ack.
  - Watchdog: the counter increments each GRANT cycle with no owner wren and no commit, and clears on any wren. When it reaches TIMEOUT, revoke: ch_gnt=0, pulse ch_abort[owner], go to IDLE.
- COMMIT: buf_in_commit=1 and buf_in_commit_len is held stable. Length rule: if commit_len > 2^ADDR_W, forward 2^ADDR_W and pulse err_len for one cycle at entry. On buf_in_commit_ack=1: drop buf_in_commit and ch_gnt, pulse ch_commit_ack[owner] for 1 cycle, and go to WAIT_LOW. The watchdog is inactive in COMMIT.
- WAIT_LOW: wait until buf_in_commit_ack=0 and the owner's ch_commit=0, then go to IDLE. This prevents double commits.
- Each ch_commit_ack pulses exactly once per commit. ch_gnt is always one-hot or zero.
- Requests from a channel that just committed are served again only after the other requesters, per the RR pointer.

Decomposition:
- Shared package usb2_pkg: FSM state encodings and the LEN_W/ADDR_W defaults.
- Sub-module usb2_rr_arb: parametrised round-robin priority picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and an index. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- Single channel (N_CH=4): ch_req[2]=1 with ready=1. Expect ch_gnt=4'b0100 one cycle later. Write addr 0..63 and commit len 64; the core sees 64 writes, then commit with len 64. Ack expects one ch_commit_ack[2] pulse.
- All four requesting continuously, each committing len 8. Grant order is 0,1,2,3,0. No overlapping grants.
- ready=0 with requests pending: no grant. Raise ready: grant issued the next cycle.
- Watchdog at TIMEOUT=16: grant ch1 with no wren. Expect ch_abort[1] pulse on cycle 16 of GRANT, then ch2 granted if it is requesting.
- commit_len=600 with ADDR_W=9: expect buf_in_commit_len=512 and a 1-cycle err_len pulse.
- reset_n low during COMMIT: buf_in_commit and ch_gnt drop asynchronously. After release, the FSM is IDLE and the RR pointer is 0.
